// File: rtl/mul_div_unit_if.sv
// Handshake and operand/result bundle for the multicycle multiply/divide unit.
//   start, op, operand_a, operand_b : control unit -> unit (op: 0 = MUL, 1 = DIV)
//   busy, done                      : unit -> control unit status
//   z_high, z_low                   : 64-bit result halves (DIV: remainder / quotient)
//   div_by_zero                     : last DIV had a zero divisor
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z_high;
  logic [WIDTH-1:0] z_low;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, z_high, z_low, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, z_high, z_low, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset, abandons any operation in flight
//   bus   : slave side of mul_div_unit_if (start/op/operands in, status/results out)
// Latency: done visible after E33 for a normal operation, after E0 for divide by zero.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clock,
  input  logic           clear,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    count;
  logic             op_q, sign_a, sign_b;
  logic [WIDTH-1:0] m_q;
  // MUL: {A[W-1:0], Q[W-1:0], q_1}; DIV: {R[W:0], Q[W-1:0]}
  logic [AW-1:0]    acc, acc_step;
  logic [WIDTH:0]   booth_sum, div_diff;
  logic [AW-1:0]    div_shift;
  logic [WIDTH-1:0] mag_a_c, mag_b_c, quo_c, rem_c;
  logic             div_zero_c;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] z_high_q, z_low_q;

  assign mag_a_c    = bus.operand_a[WIDTH-1] ? WIDTH'(-bus.operand_a) : bus.operand_a;
  assign mag_b_c    = bus.operand_b[WIDTH-1] ? WIDTH'(-bus.operand_b) : bus.operand_b;
  assign div_zero_c = bus.op && (bus.operand_b == '0);
  assign quo_c      = acc[WIDTH-1:0];
  assign rem_c      = acc[2*WIDTH-1:WIDTH];

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.z_high      = z_high_q;
  assign bus.z_low       = z_low_q;
  assign bus.div_by_zero = dbz_q;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) state_nx = div_zero_c ? S_DONE : S_CALC;
      S_CALC: if (count == CW'(WIDTH - 1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // One Booth or restoring-division step; the add is done one bit wider so a
  // most-negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    booth_sum = {acc[AW-1], acc[AW-1:WIDTH+1]};
    div_shift = {acc[AW-2:0], 1'b0};
    div_diff  = div_shift[AW-1:WIDTH] - {1'b0, m_q};
    acc_step  = acc;
    if (!op_q) begin
      case (acc[1:0])
        2'b01:   booth_sum = {acc[AW-1], acc[AW-1:WIDTH+1]} + {m_q[WIDTH-1], m_q};
        2'b10:   booth_sum = {acc[AW-1], acc[AW-1:WIDTH+1]} - {m_q[WIDTH-1], m_q};
        default: booth_sum = {acc[AW-1], acc[AW-1:WIDTH+1]};
      endcase
      acc_step = {booth_sum, acc[WIDTH:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_step = {div_diff, div_shift[WIDTH-1:1], 1'b1};
    end else begin
      acc_step = div_shift;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      z_high_q <= '0;
      z_low_q  <= '0;
      op_q     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      count    <= '0;
      m_q      <= '0;
      acc      <= '0;
    end else begin
      busy_q <= (state_nx == S_CALC) || (state_nx == S_FIX);
      done_q <= (state_nx == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sign_a <= bus.operand_a[WIDTH-1];
            sign_b <= bus.operand_b[WIDTH-1];
            count  <= '0;
            dbz_q  <= 1'b0;
            if (bus.op) begin
              m_q <= mag_b_c;
              acc <= {{(WIDTH+1){1'b0}}, mag_a_c};
            end else begin
              m_q <= bus.operand_a;
              acc <= {{WIDTH{1'b0}}, bus.operand_b, 1'b0};
            end
            if (div_zero_c) begin
              z_high_q <= bus.operand_a;
              z_low_q  <= '1;
              dbz_q    <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        S_FIX: begin
          if (!op_q) begin
            z_high_q <= acc[AW-1:WIDTH+1];
            z_low_q  <= acc[WIDTH:1];
          end else begin
            // 0x80000000 / -1 wraps to 0x80000000 through this negation
            z_low_q  <= (sign_a ^ sign_b) ? WIDTH'(-quo_c) : quo_c;
            z_high_q <= sign_a ? WIDTH'(-rem_c) : rem_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
